// File: rtl/pulse_stretch.sv
// ---------------------------------------------------------------------------
// pulse_stretch
// Turns single-cycle event ticks into human-visible level pulses: each event
// gives ON_LEN cycles high, then at least OFF_LEN cycles low. Events arriving
// while a pulse or gap is shown are held in a saturating pending counter and
// played back one after another.
//
// Build option:
//   PULSE_STRETCH_RETRIGGER_EN - retrigger mode. There is no queue. A tick
//                                during ON restarts the ON count, and a tick
//                                during GAP aborts the gap. pending and ovf
//                                read as 0.
//
// Parameters:
//   W        width of the shared ON/OFF down-counter
//   ON_LEN   high cycles per event   (1 .. 2^W-1)
//   OFF_LEN  forced low gap cycles   (1 .. 2^W-1)
//   Q        width of the pending counter (saturates at 2^Q-1)
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   tick     event strobe; each high cycle counts as one event
//   level    stretched pulse output (registered)
//   busy     high while a pulse or gap is running, or events are queued
//   pending  number of queued events not yet shown
//   ovf      sticky flag: an event was dropped because the queue was full
// ---------------------------------------------------------------------------
module pulse_stretch #(
  parameter int W       = 15,
  parameter int ON_LEN  = 32767,
  parameter int OFF_LEN = 32767,
  parameter int Q       = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  output logic         level,
  output logic         busy,
  output logic [Q-1:0] pending,
  output logic         ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [W-1:0] ON_LOAD  = W'(ON_LEN - 1);
  localparam logic [W-1:0] OFF_LOAD = W'(OFF_LEN - 1);
  localparam logic [W-1:0] Q_STEP   = W'(1'b1);

  state_t         state_r, state_s;
  logic [W-1:0]   q_r, q_s;
  logic [Q-1:0]   pend_r, pend_s;
  logic           ovf_r, ovf_s;
  logic           level_r, busy_r;
  logic           q_zero_s;

  assign q_zero_s = (q_r == {W{1'b0}});

`ifdef PULSE_STRETCH_RETRIGGER_EN

  // Next-state logic, retrigger mode: any tick (re)starts a full ON period.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    pend_s  = {Q{1'b0}};
    ovf_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick) begin
          state_s = ST_ON;
          q_s     = ON_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ON: begin
        if (tick) begin
          q_s = ON_LOAD;
        end else if (q_zero_s) begin
          state_s = ST_GAP;
          q_s     = OFF_LOAD;
        end else begin
          q_s = q_r - Q_STEP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_s = ST_ON;
          q_s     = ON_LOAD;
        end else if (q_zero_s) begin
          state_s = ST_IDLE;
        end else begin
          q_s = q_r - Q_STEP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        q_s     = {W{1'b0}};
      end
    endcase
  end

`else

  localparam logic [Q-1:0] PEND_MAX = {Q{1'b1}};
  localparam logic [Q-1:0] PEND_ONE = Q'(1'b1);

  logic inc_s, dec_s;

  // Next-state logic, queued mode: ticks seen while busy are counted and
  // replayed once the current gap completes.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    pend_s  = pend_r;
    ovf_s   = ovf_r;
    inc_s   = 1'b0;
    dec_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Pending is always 0 here, so a tick is shown directly.
        if (tick) begin
          state_s = ST_ON;
          q_s     = ON_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ON: begin
        inc_s = tick;
        if (q_zero_s) begin
          state_s = ST_GAP;
          q_s     = OFF_LOAD;
        end else begin
          q_s = q_r - Q_STEP;
        end
      end
      ST_GAP: begin
        if (q_zero_s) begin
          if (pend_r != {Q{1'b0}}) begin
            // A queued event is replayed; a coincident tick takes its place.
            state_s = ST_ON;
            q_s     = ON_LOAD;
            dec_s   = 1'b1;
            inc_s   = tick;
          end else if (tick) begin
            // Queue is empty: the tick is shown straight away, never queued.
            state_s = ST_ON;
            q_s     = ON_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          q_s   = q_r - Q_STEP;
          inc_s = tick;
        end
      end
      default: begin
        state_s = ST_IDLE;
        q_s     = {W{1'b0}};
      end
    endcase

    if (inc_s && !dec_s) begin
      if (pend_r == PEND_MAX) begin
        ovf_s = 1'b1;
      end else begin
        pend_s = pend_r + PEND_ONE;
      end
    end else if (dec_s && !inc_s) begin
      pend_s = pend_r - PEND_ONE;
    end else begin
      pend_s = pend_r;
    end
  end

`endif

  // State, counters and registered outputs; level/busy are computed from the
  // next state so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      q_r     <= {W{1'b0}};
      pend_r  <= {Q{1'b0}};
      ovf_r   <= 1'b0;
      level_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      level_r <= (state_s == ST_ON);
      busy_r  <= (state_s != ST_IDLE) || (pend_s != {Q{1'b0}});
    end
  end

  assign level   = level_r;
  assign busy    = busy_r;
  assign pending = pend_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretch
// The driver issues tick/reset on the falling edge. It updates a schedule
// model: each accepted event gets an absolute start time, which is the later
// of "next cycle" and "previous start + ON_LEN + OFF_LEN". The driver then
// pushes the expected outputs for the following cycle into a queue. A monitor
// pops one expectation after every rising edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_pulse_stretch;
  localparam int W       = 15;
  localparam int ON_LEN  = 4;
  localparam int OFF_LEN = 3;
  localparam int Q       = 2;
  localparam int PMAX    = (1 << Q) - 1;
  localparam int PERIOD  = ON_LEN + OFF_LEN;
  localparam int FAR     = -1000000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0;
  logic         level, busy, ovf;
  logic [Q-1:0] pending;

  pulse_stretch #(.W(W), .ON_LEN(ON_LEN), .OFF_LEN(OFF_LEN), .Q(Q)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .level(level), .busy(busy), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic lv;
    logic bz;
    int   pd;
    logic of;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: accepted events (tick time, pulse start time).
  int   ent_tk[$];
  int   ent_st[$];
  int   last_st = FAR;
  int   last_tk = FAR;
  logic m_ovf = 1'b0;
  int   n_cyc = 0;

  int   n_checks = 0;
  int   n_fail = 0;

  // Queued events that are waiting during cycle c.
  function automatic int pend_at(input int c);
    int k;
    k = 0;
    foreach (ent_st[i]) if (ent_tk[i] < c && ent_st[i] > c) k++;
    return k;
  endfunction

  // A queued event starts at c+1, so the pending count drops on this edge.
  function automatic bit dec_at(input int c);
    bit d;
    d = 1'b0;
    foreach (ent_st[i]) if (ent_tk[i] < c && ent_st[i] == c + 1) d = 1'b1;
    return d;
  endfunction

  function automatic logic level_at(input int c);
    logic v;
    v = 1'b0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    v = (last_tk < c) && (c <= last_tk + ON_LEN);
`else
    foreach (ent_st[i]) if (ent_st[i] <= c && c < ent_st[i] + ON_LEN) v = 1'b1;
`endif
    return v;
  endfunction

  function automatic logic busy_at(input int c);
    logic v;
    v = 1'b0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    v = (last_tk < c) && (c <= last_tk + PERIOD);
`else
    foreach (ent_st[i])
      if ((ent_tk[i] < c && ent_st[i] > c) || (ent_st[i] <= c && c < ent_st[i] + PERIOD))
        v = 1'b1;
`endif
    return v;
  endfunction

  task automatic step(input logic t, input logic r);
    exp_t e;
    int   s;
    @(negedge clk);
    tick  = t;
    reset = r;
    for (int i = ent_st.size() - 1; i >= 0; i--) begin
      if (ent_st[i] + PERIOD <= n_cyc) begin
        ent_st.delete(i);
        ent_tk.delete(i);
      end
    end
    if (r) begin
      ent_st.delete();
      ent_tk.delete();
      last_st = FAR;
      last_tk = FAR;
      m_ovf   = 1'b0;
    end else if (t) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
      last_tk = n_cyc;
`else
      if (pend_at(n_cyc) == PMAX && !dec_at(n_cyc)) begin
        m_ovf = 1'b1;
      end else begin
        s = (last_st + PERIOD > n_cyc + 1) ? last_st + PERIOD : n_cyc + 1;
        ent_tk.push_back(n_cyc);
        ent_st.push_back(s);
        last_st = s;
      end
`endif
    end
    e.cyc = n_cyc + 1;
    e.lv  = level_at(n_cyc + 1);
    e.bz  = busy_at(n_cyc + 1);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    e.pd  = 0;
    e.of  = 1'b0;
`else
    e.pd  = pend_at(n_cyc + 1);
    e.of  = m_ovf;
`endif
    exp_q.push_back(e);
    n_cyc++;
  endtask

  task automatic check_val(input string name, input int cyc, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual %0d required %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("level",   e.cyc, int'(level),   int'(e.lv));
        check_val("busy",    e.cyc, int'(busy),    int'(e.bz));
        check_val("pending", e.cyc, int'(pending), e.pd);
        check_val("ovf",     e.cyc, int'(ovf),     int'(e.of));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dens;
    // Reset state.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    // Single tick from IDLE.
    step(1'b1, 1'b0);
    repeat (15) step(1'b0, 1'b0);
    // Ticks at offsets 0, 2, 3: three back-to-back pulses.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0);
    // Tick held for 6 cycles: saturation and overflow.
    repeat (6) step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);
    // Clear ovf, then a tick exactly on the gap terminal cycle.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (PERIOD - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (15) step(1'b0, 1'b0);
    // Reset during ON with two events queued.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);
    // Random traffic with varying tick density and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       dens = 8;
        1:       dens = 35;
        default: dens = 85;
      endcase
      step(logic'($urandom_range(0, 99) < dens), logic'($urandom_range(0, 299) == 0));
    end
    repeat (20) step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Output-side counterpart of the input debouncer: converts single-cycle event ticks (e.g. a debounced button tick or a game "hit" event) into clean, human-visible level pulses of fixed ON length, separated by a guaranteed OFF gap. It drives LEDs or buzzer enables, so every event shows up as a distinct blink. Events arriving during a blink are queued in a saturating counter rather than lost.

## Interface
- `W`, 15: width of the ON/OFF down-counters.
- `ON_LEN`, 32767: cycles the output stays high per event; range 1..2^W-1.
- `OFF_LEN`, 32767: cycles of forced low gap after each pulse; range 1..2^W-1.
- `Q`, 3: width of the pending-event counter; it saturates at 2^Q-1.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  event strobe, one per cycle high = one event.
- `level`  out  1  stretched pulse output.
- `busy`  out  1  high when the state is not IDLE or pending is not 0.
- `pending`  out  Q  queued events not yet displayed.
- `ovf`  out  1  sticky flag: an event was dropped because the queue was full.

## Operation
- FSM states are IDLE, ON and GAP. One W-bit counter `q` is shared by ON and GAP.
- IDLE:
  - `level`=0.
  - If `tick` is high, go to ON and load `q`=ON_LEN-1.
- ON:
  - `level`=1.
  - Decrement `q` each cycle.
  - When `q`==0, go to GAP and load `q`=OFF_LEN-1.
- GAP:
  - `level`=0.
  - Decrement `q` each cycle.
  - When `q`==0: if `pending`>0 or `tick` is high, go to ON and load ON_LEN-1; otherwise go to IDLE.
- Pending counter update, all on the same edge:
  - Increment when `tick` is high in ON, or in GAP other than the terminal cycle.
  - Decrement when the GAP terminal cycle starts a pulse from the queue.
  - In the GAP terminal cycle with `tick` high and `pending`>0: the tick is queued and one queued event is consumed, so `pending` is unchanged.
  - In the GAP terminal cycle with `tick` high and `pending`==0: the tick is consumed directly and `pending` stays 0.
- Saturation: if `tick` arrives when `pending`==2^Q-1 and no decrement happens that cycle, `pending` holds and `ovf` is set.
- `ovf` is cleared only by `reset`.
- `level` and `busy` are registered or decoded from registered state only, so they are glitch-free.

## Timing
- Reset values: state IDLE, `q`=0, `level`=0, `busy`=0, `pending`=0, `ovf`=0.
- `reset` mid-pulse drops `level` on the next edge and discards the queue.
- Latency: `tick` sampled in IDLE at edge k gives `level`=1 from cycle k+1 for exactly ON_LEN cycles.
- Each pulse is followed by exactly OFF_LEN low cycles before the next rising edge of `level`.
- Back-to-back queued events give a period of ON_LEN+OFF_LEN cycles.
- `tick` held high for n cycles counts as n events.
- `busy` falls in the same cycle the state enters IDLE with `pending`==0.
- Minimum parameters ON_LEN=OFF_LEN=1 give a 1-high/1-low pattern.

## Configuration
- `PULSE_STRETCH_RETRIGGER_EN` defined (retrigger mode):
  - No queue: `pending` is tied to 0 and `ovf` is tied to 0.
  - `tick` in ON reloads `q`=ON_LEN-1, extending the pulse.
  - `tick` in GAP enters ON on the next edge, aborting the gap.
  - Use case: "activity" LEDs.
- Undefined (default): the queued behaviour described above.

## Test plan
Parameters for all scenarios: ON_LEN=4, OFF_LEN=3, Q=2.
- Single tick in IDLE at cycle 10 -> `level` high in cycles 11–14 and low from 15; `busy` low from cycle 18.
- Ticks at cycles 10, 12, 13 -> three pulses rising at 11, 18, 25, each 4 cycles long; `pending` peaks at 2; `ovf`=0.
- `tick` held high for 6 cycles from IDLE -> first pulse plus 3 queued events; `pending` saturates at 3 and `ovf`=1 after the 5th and 6th ticks; 4 pulses total.
- Tick exactly on the GAP terminal cycle with `pending`=0 -> next pulse rises on the following cycle with no IDLE cycle; `pending` stays 0.
- `reset` asserted during ON with `pending`=2 -> next cycle all outputs are 0 and no further pulses occur.
- With `PULSE_STRETCH_RETRIGGER_EN`: ticks at 10 and 13 -> `level` high in cycles 11–17; a tick in GAP at cycle 19 -> `level` rises at cycle 20; `pending` and `ovf` are always 0.
